// File: rtl/pcpu_hazard_unit.sv
// Hazard/forwarding controller: tracks D in-flight instructions past ID and drives
// forward selects, load-use stalls, redirect flushes, memory freezes and perf counters.
module pcpu_hazard_unit #(
  parameter int unsigned D          = 3,
  parameter int unsigned RA_W       = 5,
  parameter int unsigned LOAD_READY = 1,
  parameter bit          FORWARD_EN = 1'b1,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_id_valid,
  input  logic [RA_W-1:0]  i_id_rs,
  input  logic [RA_W-1:0]  i_id_rt,
  input  logic             i_id_rs_used,
  input  logic             i_id_rt_used,
  input  logic             i_id_rf_we,
  input  logic [RA_W-1:0]  i_id_rf_dst,
  input  logic             i_id_is_load,
  input  logic             i_ex_redirect,
  input  logic             i_mem_busy,
  output logic             o_stall_if,
  output logic             o_stall_id,
  output logic             o_bubble_ex,
  output logic             o_flush_id,
  output logic             o_freeze,
  output logic [3:0]       o_fwd_a_sel,
  output logic [3:0]       o_fwd_b_sel,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  logic [D-1:0]    r_v;
  logic [D-1:0]    r_we;
  logic [D-1:0]    r_ld;
  logic [RA_W-1:0] r_dst [D];
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic        w_a_hit, w_a_ld, w_a_ok, w_a_blk;
  logic        w_b_hit, w_b_ld, w_b_ok, w_b_blk;
  int unsigned w_a_k, w_b_k;
  logic [3:0]  w_a_sel, w_b_sel;
  logic        w_hazard;

  // Scan oldest to youngest so the youngest matching producer ends up selected.
  always_comb begin
    w_a_hit = 1'b0;
    w_a_ld  = 1'b0;
    w_a_k   = 0;
    w_b_hit = 1'b0;
    w_b_ld  = 1'b0;
    w_b_k   = 0;
    for (int k = int'(D) - 1; k >= 0; k--) begin
      if (i_id_rs_used && r_v[k] && r_we[k] && (r_dst[k] == i_id_rs) && (i_id_rs != '0)) begin
        w_a_hit = 1'b1;
        w_a_ld  = r_ld[k];
        w_a_k   = unsigned'(k);
      end
      if (i_id_rt_used && r_v[k] && r_we[k] && (r_dst[k] == i_id_rt) && (i_id_rt != '0)) begin
        w_b_hit = 1'b1;
        w_b_ld  = r_ld[k];
        w_b_k   = unsigned'(k);
      end
    end
    w_a_ok   = FORWARD_EN && (!w_a_ld || (w_a_k >= LOAD_READY));
    w_b_ok   = FORWARD_EN && (!w_b_ld || (w_b_k >= LOAD_READY));
    w_a_blk  = w_a_hit && !w_a_ok;
    w_b_blk  = w_b_hit && !w_b_ok;
    w_a_sel  = (w_a_hit && w_a_ok) ? 4'(w_a_k + 1) : 4'd0;
    w_b_sel  = (w_b_hit && w_b_ok) ? 4'(w_b_k + 1) : 4'd0;
    w_hazard = i_id_valid && (w_a_blk || w_b_blk);
  end

  always_comb begin
    o_stall_if  = 1'b0;
    o_stall_id  = 1'b0;
    o_bubble_ex = 1'b0;
    o_flush_id  = 1'b0;
    o_freeze    = 1'b0;
    o_fwd_a_sel = 4'd0;
    o_fwd_b_sel = 4'd0;
    if (!rst) begin
      o_fwd_a_sel = w_a_sel;
      o_fwd_b_sel = w_b_sel;
      if (i_mem_busy) begin
        o_freeze   = 1'b1;
        o_stall_if = 1'b1;
        o_stall_id = 1'b1;
      end else if (i_ex_redirect) begin
        o_flush_id  = 1'b1;
        o_bubble_ex = 1'b1;
      end else if (w_hazard) begin
        o_stall_if  = 1'b1;
        o_stall_id  = 1'b1;
        o_bubble_ex = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v         <= '0;
      r_we        <= '0;
      r_ld        <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
      for (int k = 0; k < int'(D); k++) r_dst[k] <= '0;
    end else begin
      if (o_stall_if && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (o_flush_id && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      if (!o_freeze) begin
        for (int k = 1; k < int'(D); k++) begin
          r_v[k]   <= r_v[k-1];
          r_we[k]  <= r_we[k-1];
          r_ld[k]  <= r_ld[k-1];
          r_dst[k] <= r_dst[k-1];
        end
        // Entry D-1 drops off the end: its RF write lands on this edge.
        r_v[0]   <= i_id_valid && !o_bubble_ex;
        r_we[0]  <= i_id_rf_we && !o_bubble_ex;
        r_ld[0]  <= i_id_is_load && !o_bubble_ex;
        r_dst[0] <= o_bubble_ex ? '0 : i_id_rf_dst;
      end
    end
  end

  assign o_stall_cnt = r_stall_cnt;
  assign o_flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pcpu_hazard_unit.sv
// Directed bench: forwarding instance (defaults) and a no-forward, 2-bit-counter instance
// share one set of inputs.
module tb_pcpu_hazard_unit;

  logic       clk;
  logic       rst;
  logic       i_id_valid, i_id_rs_used, i_id_rt_used, i_id_rf_we, i_id_is_load;
  logic [4:0] i_id_rs, i_id_rt, i_id_rf_dst;
  logic       i_ex_redirect, i_mem_busy;

  logic        a_stall_if, a_stall_id, a_bubble_ex, a_flush_id, a_freeze;
  logic [3:0]  a_fwd_a, a_fwd_b;
  logic [31:0] a_stall_cnt, a_flush_cnt;
  logic        b_stall_if, b_stall_id, b_bubble_ex, b_flush_id, b_freeze;
  logic [3:0]  b_fwd_a, b_fwd_b;
  logic [1:0]  b_stall_cnt, b_flush_cnt;

  int checks = 0;
  int errors = 0;

  pcpu_hazard_unit dut_a (
    .clk(clk), .rst(rst), .i_id_valid(i_id_valid), .i_id_rs(i_id_rs), .i_id_rt(i_id_rt),
    .i_id_rs_used(i_id_rs_used), .i_id_rt_used(i_id_rt_used), .i_id_rf_we(i_id_rf_we),
    .i_id_rf_dst(i_id_rf_dst), .i_id_is_load(i_id_is_load), .i_ex_redirect(i_ex_redirect),
    .i_mem_busy(i_mem_busy), .o_stall_if(a_stall_if), .o_stall_id(a_stall_id),
    .o_bubble_ex(a_bubble_ex), .o_flush_id(a_flush_id), .o_freeze(a_freeze),
    .o_fwd_a_sel(a_fwd_a), .o_fwd_b_sel(a_fwd_b), .o_stall_cnt(a_stall_cnt),
    .o_flush_cnt(a_flush_cnt)
  );

  pcpu_hazard_unit #(.FORWARD_EN(1'b0), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .i_id_valid(i_id_valid), .i_id_rs(i_id_rs), .i_id_rt(i_id_rt),
    .i_id_rs_used(i_id_rs_used), .i_id_rt_used(i_id_rt_used), .i_id_rf_we(i_id_rf_we),
    .i_id_rf_dst(i_id_rf_dst), .i_id_is_load(i_id_is_load), .i_ex_redirect(i_ex_redirect),
    .i_mem_busy(i_mem_busy), .o_stall_if(b_stall_if), .o_stall_id(b_stall_id),
    .o_bubble_ex(b_bubble_ex), .o_flush_id(b_flush_id), .o_freeze(b_freeze),
    .o_fwd_a_sel(b_fwd_a), .o_fwd_b_sel(b_fwd_b), .o_stall_cnt(b_stall_cnt),
    .o_flush_cnt(b_flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    i_id_valid = 0; i_id_rs_used = 0; i_id_rt_used = 0; i_id_rf_we = 0; i_id_is_load = 0;
    i_id_rs = 0; i_id_rt = 0; i_id_rf_dst = 0; i_ex_redirect = 0; i_mem_busy = 0;
  endtask

  // ID holds an instruction that reads nothing.
  task automatic issue(input logic we, input logic [4:0] dst, input logic ld);
    clear_in();
    i_id_valid = 1; i_id_rf_we = we; i_id_rf_dst = dst; i_id_is_load = ld;
  endtask

  // ID holds a non-writing consumer.
  task automatic consume(input logic [4:0] rs, input logic rsu, input logic [4:0] rt,
                         input logic rtu);
    clear_in();
    i_id_valid = 1; i_id_rs = rs; i_id_rs_used = rsu; i_id_rt = rt; i_id_rt_used = rtu;
  endtask

  task automatic do_reset();
    rst = 1; clear_in(); step(); step(); rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; i_mem_busy = 1; i_ex_redirect = 1; i_id_valid = 1;
    #1;
    checks++; if (a_freeze !== 1'b0) begin errors++; $display("FAIL rst_freeze got %0b want 0", a_freeze); end
    checks++; if (a_stall_if !== 1'b0) begin errors++; $display("FAIL rst_stall got %0b want 0", a_stall_if); end
    checks++; if (a_flush_id !== 1'b0) begin errors++; $display("FAIL rst_flush got %0b want 0", a_flush_id); end
    step(); step();
    rst = 0; clear_in();
    #1;
    checks++; if (a_stall_cnt !== 32'd0) begin errors++; $display("FAIL rst_scnt got %0d want 0", a_stall_cnt); end
    checks++; if (a_flush_cnt !== 32'd0) begin errors++; $display("FAIL rst_fcnt got %0d want 0", a_flush_cnt); end
    checks++; if (b_stall_cnt !== 2'd0) begin errors++; $display("FAIL rst_bscnt got %0d want 0", b_stall_cnt); end
  endtask

  task automatic test_forward();
    do_reset();
    issue(1, 5'd1, 0); step();
    consume(5'd1, 1, 5'd2, 1); i_id_rf_we = 1; i_id_rf_dst = 5'd3;
    #1;
    checks++; if (a_fwd_a !== 4'd1) begin errors++; $display("FAIL t1_fwd_a got %0d want 1", a_fwd_a); end
    checks++; if (a_fwd_b !== 4'd0) begin errors++; $display("FAIL t1_fwd_b got %0d want 0", a_fwd_b); end
    checks++; if (a_stall_if !== 1'b0) begin errors++; $display("FAIL t1_stall got %0b want 0", a_stall_if); end
    step();
    consume(5'd1, 1, 5'd3, 1);
    #1;
    checks++; if (a_fwd_a !== 4'd2) begin errors++; $display("FAIL t1_fwd_a2 got %0d want 2", a_fwd_a); end
    checks++; if (a_fwd_b !== 4'd1) begin errors++; $display("FAIL t1_fwd_b2 got %0d want 1", a_fwd_b); end
  endtask

  task automatic test_load_use();
    do_reset();
    issue(1, 5'd2, 1); step();
    consume(5'd2, 1, 5'd0, 1);
    #1;
    checks++; if (a_stall_if !== 1'b1) begin errors++; $display("FAIL t2_stall_if got %0b want 1", a_stall_if); end
    checks++; if (a_stall_id !== 1'b1) begin errors++; $display("FAIL t2_stall_id got %0b want 1", a_stall_id); end
    checks++; if (a_bubble_ex !== 1'b1) begin errors++; $display("FAIL t2_bubble got %0b want 1", a_bubble_ex); end
    checks++; if (a_fwd_a !== 4'd0) begin errors++; $display("FAIL t2_sel0 got %0d want 0", a_fwd_a); end
    step();
    checks++; if (a_stall_if !== 1'b0) begin errors++; $display("FAIL t2_stall_if2 got %0b want 0", a_stall_if); end
    checks++; if (a_fwd_a !== 4'd2) begin errors++; $display("FAIL t2_sel got %0d want 2", a_fwd_a); end
    checks++; if (a_fwd_b !== 4'd0) begin errors++; $display("FAIL t2_sel_r0 got %0d want 0", a_fwd_b); end
    checks++; if (a_stall_cnt !== 32'd1) begin errors++; $display("FAIL t2_scnt got %0d want 1", a_stall_cnt); end
  endtask

  task automatic test_r0_and_youngest();
    do_reset();
    issue(1, 5'd0, 0); step();
    consume(5'd0, 1, 5'd0, 1);
    #1;
    checks++; if (a_fwd_a !== 4'd0) begin errors++; $display("FAIL t3_r0_a got %0d want 0", a_fwd_a); end
    checks++; if (a_stall_if !== 1'b0) begin errors++; $display("FAIL t3_r0_stall got %0b want 0", a_stall_if); end
    issue(1, 5'd5, 0); step();
    issue(1, 5'd6, 0); step();
    issue(1, 5'd5, 0); step();
    consume(5'd5, 1, 5'd6, 1);
    #1;
    checks++; if (a_fwd_a !== 4'd1) begin errors++; $display("FAIL t3_young got %0d want 1", a_fwd_a); end
    checks++; if (a_fwd_b !== 4'd2) begin errors++; $display("FAIL t3_mid got %0d want 2", a_fwd_b); end
  endtask

  task automatic test_redirect();
    do_reset();
    issue(1, 5'd7, 1); step();
    consume(5'd7, 1, 5'd0, 0); i_id_rf_we = 1; i_id_rf_dst = 5'd9; i_ex_redirect = 1;
    #1;
    checks++; if (a_flush_id !== 1'b1) begin errors++; $display("FAIL t4_flush got %0b want 1", a_flush_id); end
    checks++; if (a_bubble_ex !== 1'b1) begin errors++; $display("FAIL t4_bubble got %0b want 1", a_bubble_ex); end
    checks++; if (a_stall_if !== 1'b0) begin errors++; $display("FAIL t4_stall got %0b want 0", a_stall_if); end
    step();
    consume(5'd9, 1, 5'd7, 1);
    #1;
    checks++; if (a_flush_cnt !== 32'd1) begin errors++; $display("FAIL t4_fcnt got %0d want 1", a_flush_cnt); end
    checks++; if (a_fwd_a !== 4'd0) begin errors++; $display("FAIL t4_e0_empty got %0d want 0", a_fwd_a); end
    checks++; if (a_fwd_b !== 4'd2) begin errors++; $display("FAIL t4_ld_e1 got %0d want 2", a_fwd_b); end
    checks++; if (a_stall_cnt !== 32'd0) begin errors++; $display("FAIL t4_scnt got %0d want 0", a_stall_cnt); end
  endtask

  task automatic test_freeze();
    do_reset();
    issue(1, 5'd3, 1); step();
    consume(5'd3, 1, 5'd0, 0); i_mem_busy = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (a_freeze !== 1'b1) begin errors++; $display("FAIL t5_freeze%0d got %0b want 1", i, a_freeze); end
      checks++; if (a_bubble_ex !== 1'b0) begin errors++; $display("FAIL t5_bub%0d got %0b want 0", i, a_bubble_ex); end
      step();
    end
    i_mem_busy = 0;
    #1;
    checks++; if (a_freeze !== 1'b0) begin errors++; $display("FAIL t5_unfreeze got %0b want 0", a_freeze); end
    checks++; if (a_bubble_ex !== 1'b1) begin errors++; $display("FAIL t5_hazard got %0b want 1", a_bubble_ex); end
    checks++; if (a_stall_cnt !== 32'd3) begin errors++; $display("FAIL t5_scnt got %0d want 3", a_stall_cnt); end
    step();
    checks++; if (a_fwd_a !== 4'd2) begin errors++; $display("FAIL t5_sel got %0d want 2", a_fwd_a); end
    checks++; if (a_stall_cnt !== 32'd4) begin errors++; $display("FAIL t5_scnt2 got %0d want 4", a_stall_cnt); end
  endtask

  task automatic test_no_forward();
    do_reset();
    issue(1, 5'd1, 0); step();
    consume(5'd1, 1, 5'd0, 0);
    #1;
    checks++; if (a_fwd_a !== 4'd1) begin errors++; $display("FAIL t6_a_sel got %0d want 1", a_fwd_a); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (b_stall_if !== 1'b1) begin errors++; $display("FAIL t6_stall%0d got %0b want 1", i, b_stall_if); end
      checks++; if (b_fwd_a !== 4'd0) begin errors++; $display("FAIL t6_sel%0d got %0d want 0", i, b_fwd_a); end
      step();
    end
    checks++; if (b_stall_if !== 1'b0) begin errors++; $display("FAIL t6_go got %0b want 0", b_stall_if); end
    checks++; if (b_fwd_a !== 4'd0) begin errors++; $display("FAIL t6_go_sel got %0d want 0", b_fwd_a); end
    checks++; if (b_stall_cnt !== 2'd3) begin errors++; $display("FAIL t6_scnt got %0d want 3", b_stall_cnt); end
    i_mem_busy = 1; step(); step(); i_mem_busy = 0;
    #1;
    checks++; if (b_stall_cnt !== 2'd3) begin errors++; $display("FAIL t6_sat got %0d want 3", b_stall_cnt); end
    issue(1, 5'd1, 0); step();
    consume(5'd1, 1, 5'd0, 0);
    #1;
    checks++; if (b_stall_if !== 1'b1) begin errors++; $display("FAIL t6_stall_b got %0b want 1", b_stall_if); end
    step();
    rst = 1;
    #1;
    checks++; if (b_stall_if !== 1'b0) begin errors++; $display("FAIL t6_rst_stall got %0b want 0", b_stall_if); end
    checks++; if (b_bubble_ex !== 1'b0) begin errors++; $display("FAIL t6_rst_bub got %0b want 0", b_bubble_ex); end
    step();
    rst = 0;
    #1;
    checks++; if (b_stall_if !== 1'b0) begin errors++; $display("FAIL t6_post_stall got %0b want 0", b_stall_if); end
    checks++; if (b_stall_cnt !== 2'd0) begin errors++; $display("FAIL t6_post_scnt got %0d want 0", b_stall_cnt); end
    checks++; if (a_stall_cnt !== 32'd0) begin errors++; $display("FAIL t6_post_ascnt got %0d want 0", a_stall_cnt); end
  endtask

  initial begin
    rst = 1;
    clear_in();
    test_reset();
    test_forward();
    test_load_use();
    test_r0_and_youngest();
    test_redirect();
    test_freeze();
    test_no_forward();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
